// File: rtl/sdio_dat_txn.sv
`default_nettype none
// ============================================================================
//  Module   : sdio_dat_txn
//  Purpose  : Card-side SDIO read-data transmitter. Serialises a 32-bit word
//             stream into SD data blocks (start, payload, per-lane CRC16, end)
//             on 1, 4 or 8 lanes, with runtime length/count/stop control.
//  Revision : 1.0  initial release
// ============================================================================
module sdio_dat_txn #(
    parameter int NUMIO      = 8,
    parameter int LGBLK      = 9,
    parameter int GAP_CYCLES = 2
) (
    input  logic             sd_clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_width,
    input  logic [LGBLK:0]   i_len,
    input  logic [15:0]      i_nblocks,
    input  logic             i_stop,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_data,
    output logic [NUMIO-1:0] o_dat,
    output logic [NUMIO-1:0] o_dat_oe,
    output logic             o_busy,
    output logic             o_blk_done,
    output logic             o_done,
    output logic             o_underrun
);

    localparam int            CW         = LGBLK + 4;
    localparam logic [CW-1:0] c_gap_last = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] c_crc_last = CW'(15);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_CRC   = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_fin;
    logic                    r_en_d;
    logic [1:0]              r_wsel;        // 0: 1 lane, 1: 4 lanes, 2: 8 lanes
    logic [1:0]              w_wsel_req;
    logic [CW-1:0]           r_ndata_m1;
    logic [15:0]             r_nblocks;
    logic [15:0]             r_blk_cnt;
    logic [CW-1:0]           r_cnt;
    logic [31:0]             r_hold;
    logic                    r_hold_valid;
    logic [31:0]             r_shift;
    logic [NUMIO-1:0][15:0]  r_crc;
    logic [NUMIO-1:0][15:0]  w_crc_upd;
    logic                    r_stop_pend;
    logic                    r_underrun;
    logic                    r_blk_done;
    logic                    r_done;
    logic [NUMIO-1:0]        w_act;
    logic [7:0]              w_lane_bits;
    logic                    w_rise;
    logic                    w_last_data;
    logic                    w_word_end;
    logic                    w_more;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_drive;

    assign w_rise      = i_en && !r_en_d;
    assign w_last_data = (r_cnt == r_ndata_m1);
    assign w_more      = (r_nblocks == 16'd0) ||
                         (({1'b0, r_blk_cnt} + 17'd1) < {1'b0, r_nblocks});
    assign o_busy      = (r_state != S_IDLE);
    assign o_ready     = (r_state != S_IDLE) && !r_hold_valid;
    assign w_accept    = i_valid && o_ready;
    // Shifter loads at START and at each word boundary except after the last word
    assign w_load      = i_en && ((r_state == S_START) ||
                         ((r_state == S_DATA) && w_word_end && !w_last_data));
    assign w_drive     = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_CRC)   || (r_state == S_END);
    assign o_blk_done  = r_blk_done;
    assign o_done      = r_done;
    assign o_underrun  = r_underrun;

    // Requested width decode, clamped to the physical lane count
    always_comb begin
        w_wsel_req = (i_width == 2'd1) ? 2'd1 : (i_width == 2'd2) ? 2'd2 : 2'd0;
        if (w_wsel_req == 2'd2 && NUMIO < 8) w_wsel_req = (NUMIO >= 4) ? 2'd1 : 2'd0;
        if (w_wsel_req == 2'd1 && NUMIO < 4) w_wsel_req = 2'd0;
    end

    // Current lane bits from the top of the shifter and word-boundary detect
    always_comb begin
        w_lane_bits = 8'hFF;
        w_word_end  = 1'b0;
        case (r_wsel)
            2'd1: begin
                w_lane_bits = {4'hF, r_shift[31:28]};
                w_word_end  = (r_cnt[2:0] == 3'h7);
            end
            2'd2: begin
                w_lane_bits = r_shift[31:24];
                w_word_end  = (r_cnt[1:0] == 2'h3);
            end
            default: begin
                w_lane_bits = {7'h7F, r_shift[31]};
                w_word_end  = (r_cnt[4:0] == 5'h1F);
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUMIO; gi++) begin : g_lane
            assign w_act[gi]     = (gi == 0) || ((gi < 4) && (r_wsel != 2'd0)) || (r_wsel == 2'd2);
            assign w_crc_upd[gi] = {r_crc[gi][14:0], 1'b0} ^
                                   ({16{r_crc[gi][15] ^ w_lane_bits[gi]}} & 16'h1021);
            assign o_dat_oe[gi]  = w_act[gi] && w_drive;
            assign o_dat[gi]     = !(w_act[gi] && w_drive) ? 1'b1 :
                                   (r_state == S_DATA) ? w_lane_bits[gi] :
                                   (r_state == S_CRC)  ? r_crc[gi][15] :
                                   (r_state == S_END);
        end
    endgenerate

    // State register
    always_ff @(posedge sd_clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; an enable drop overrides every other transition
    always_comb begin
        w_next = r_state;
        w_fin  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_rise) w_next = S_GAP;
            S_GAP: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                    w_fin  = 1'b1;
                end else if (r_cnt == c_gap_last) begin
                    w_next = S_START;
                end
            end
            S_START: w_next = S_DATA;
            S_DATA:  if (w_last_data) w_next = S_CRC;
            S_CRC:   if (r_cnt == c_crc_last) w_next = S_END;
            S_END: begin
                if (w_more && !r_stop_pend && !i_stop) begin
                    w_next = S_GAP;
                end else begin
                    w_next = S_IDLE;
                    w_fin  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && !i_en) begin
            w_next = S_IDLE;
            w_fin  = 1'b0;
        end
    end

    // Datapath: session parameters, counters, hold/shifter, CRCs and status
    always_ff @(posedge sd_clk) begin
        if (!rst_n) begin
            r_en_d       <= 1'b0;
            r_wsel       <= 2'd0;
            r_ndata_m1   <= '0;
            r_nblocks    <= '0;
            r_blk_cnt    <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_crc        <= '0;
            r_stop_pend  <= 1'b0;
            r_underrun   <= 1'b0;
            r_blk_done   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_en_d     <= i_en;
            r_blk_done <= (r_state == S_END) && i_en;
            r_done     <= w_fin;
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + 1'b1;

            if (r_state == S_IDLE && w_rise) begin
                r_wsel     <= w_wsel_req;
                r_nblocks  <= i_nblocks;
                r_blk_cnt  <= '0;
                r_underrun <= 1'b0;
                case (w_wsel_req)
                    2'd1:    r_ndata_m1 <= CW'({i_len, 1'b0}) - 1'b1;
                    2'd2:    r_ndata_m1 <= CW'(i_len) - 1'b1;
                    default: r_ndata_m1 <= {i_len, 3'b000} - 1'b1;
                endcase
            end

            if (r_state == S_END) r_blk_cnt <= r_blk_cnt + 16'd1;

            if (w_next == S_IDLE)
                r_stop_pend <= 1'b0;
            else if (i_stop && w_drive)
                r_stop_pend <= 1'b1;

            // Hold register: bypassed when empty at a load, flushed on exit
            if (w_next == S_IDLE || w_load) begin
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold       <= i_data;
                r_hold_valid <= 1'b1;
            end

            if (w_load) begin
                if (r_hold_valid) begin
                    r_shift <= r_hold;
                end else if (w_accept) begin
                    r_shift <= i_data;
                end else begin
                    r_shift    <= 32'h0;
                    r_underrun <= 1'b1;
                end
            end else if (r_state == S_DATA) begin
                case (r_wsel)
                    2'd1:    r_shift <= {r_shift[27:0], 4'h0};
                    2'd2:    r_shift <= {r_shift[23:0], 8'h0};
                    default: r_shift <= {r_shift[30:0], 1'b0};
                endcase
            end

            if (r_state == S_START) begin
                r_crc <= '0;
            end else if (r_state == S_DATA) begin
                for (int l = 0; l < NUMIO; l++)
                    if (w_act[l]) r_crc[l] <= w_crc_upd[l];
            end else if (r_state == S_CRC) begin
                for (int l = 0; l < NUMIO; l++)
                    r_crc[l] <= {r_crc[l][14:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire
